// File: rtl/gate_truth_checker_pkg.sv
// Shared types and constants for the gate block self-test: FSM states,
// response bit positions and the golden truth table.
package gate_chk_pkg;

  localparam int unsigned OUT_W   = 7;
  localparam int unsigned NUM_VEC = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned NOR_B  = 0;
  localparam int unsigned NOTA_B = 1;
  localparam int unsigned AND_B  = 2;
  localparam int unsigned OR_B   = 3;
  localparam int unsigned NAND_B = 4;
  localparam int unsigned XOR_B  = 5;
  localparam int unsigned XNOR_B = 6;

  // Entry i is the expected response for {a,b} = i.
  localparam logic [NUM_VEC-1:0][OUT_W-1:0] GOLDEN = {
    7'h4C,  // 11
    7'h38,  // 10
    7'h3A,  // 01
    7'h53   // 00
  };

endpackage

// File: rtl/gate_truth_checker_golden_rom.sv
// Combinational lookup of the expected gate block response for one input vector.
module gate_golden_rom
  import gate_chk_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic [OUT_W-1:0] golden_o
);

  assign golden_o = GOLDEN[idx_i];

endmodule

// File: rtl/gate_truth_checker.sv
// Built-in self-test for the gate block: walks a,b through all four vectors,
// waits for the response to settle, and accumulates mismatches against golden.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_OUT       = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               dut_a,
  output logic               dut_b,
  input  logic [OUT_W-1:0]   dut_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] err_vec,
  output logic [OUT_W-1:0]   err_bits,
  output logic [IDX_W-1:0]   vec_idx
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  if (NUM_OUT != OUT_W) begin : g_bad_num_out
    $error("gate_truth_checker: NUM_OUT must be 7");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   vec_q, vec_d;
  logic               a_q, a_d, b_q, b_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [NUM_VEC-1:0] err_vec_q, err_vec_d;
  logic [OUT_W-1:0]   err_bits_q, err_bits_d;
  logic [OUT_W-1:0]   golden;
  logic [OUT_W-1:0]   mism;

  gate_golden_rom u_rom (
    .idx_i    (vec_q),
    .golden_o (golden)
  );

  // Case-inequality so that X/Z on the response is reported as a mismatch.
  always_comb begin
    mism = '0;
    for (int i = 0; i < int'(OUT_W); i++) begin
      mism[i] = (dut_out[i] !== golden[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (cnt_q == '0) state_d = SAMPLE;
      SAMPLE:  state_d = (vec_q == IDX_W'(NUM_VEC - 1)) ? DONE : DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    a_d        = a_q;
    b_d        = b_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_vec_d  = err_vec_q;
    err_bits_d = err_bits_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vec_d      = '0;
          a_d        = 1'b0;
          b_d        = 1'b0;
          cnt_d      = CNT_LOAD;
          err_vec_d  = '0;
          err_bits_d = '0;
          pass_d     = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      SAMPLE: begin
        err_bits_d        = err_bits_q | mism;
        err_vec_d[vec_q]  = err_vec_q[vec_q] | (|mism);
        if (vec_q == IDX_W'(NUM_VEC - 1)) begin
          done_d = 1'b1;
          pass_d = (err_vec_d == '0);
        end else begin
          vec_d = vec_q + IDX_W'(1);
          a_d   = vec_d[1];
          b_d   = vec_d[0];
          cnt_d = CNT_LOAD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      vec_q      <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_vec_q  <= '0;
      err_bits_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      vec_q      <= vec_d;
      a_q        <= a_d;
      b_q        <= b_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_vec_q  <= err_vec_d;
      err_bits_q <= err_bits_d;
    end
  end

  assign busy     = (state_q == DRIVE) || (state_q == SAMPLE);
  assign dut_a    = a_q;
  assign dut_b    = b_q;
  assign vec_idx  = vec_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_vec  = err_vec_q;
  assign err_bits = err_bits_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench: two checkers (settle 2 and settle 1) each driving a
// behavioural gate block with selectable injected faults.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start2 = 1'b0, start1 = 1'b0;
  int   fault2 = 0, fault1 = 0;
  int   sel = 0;

  logic d2_a, d2_b, d2_busy, d2_done, d2_pass;
  logic [3:0] d2_err_vec;
  logic [6:0] d2_err_bits, d2_out;
  logic [1:0] d2_vec;
  logic d1_a, d1_b, d1_busy, d1_done, d1_pass;
  logic [3:0] d1_err_vec;
  logic [6:0] d1_err_bits, d1_out;
  logic [1:0] d1_vec;

  logic m_a, m_b, m_busy, m_done, m_pass;
  logic [3:0] m_err_vec;
  logic [6:0] m_err_bits;
  logic [1:0] m_vec;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Behavioural gate block; fault 1 = xorab stuck 0, fault 2 = andab/nandab swapped.
  function automatic logic [6:0] gate_model(input logic a, input logic b, input int fault);
    logic [6:0] r;
    logic t;
    r[0] = ~(a | b);
    r[1] = ~a;
    r[2] = a & b;
    r[3] = a | b;
    r[4] = ~(a & b);
    r[5] = a ^ b;
    r[6] = ~(a ^ b);
    if (fault == 1) r[5] = 1'b0;
    if (fault == 2) begin
      t = r[2]; r[2] = r[4]; r[4] = t;
    end
    return r;
  endfunction

  assign d2_out = gate_model(d2_a, d2_b, fault2);
  assign d1_out = gate_model(d1_a, d1_b, fault1);

  gate_truth_checker #(.SETTLE_CYCLES(2), .NUM_OUT(7)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_a(d2_a), .dut_b(d2_b),
    .dut_out(d2_out), .busy(d2_busy), .done(d2_done), .pass(d2_pass),
    .err_vec(d2_err_vec), .err_bits(d2_err_bits), .vec_idx(d2_vec)
  );

  gate_truth_checker #(.SETTLE_CYCLES(1), .NUM_OUT(7)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_a(d1_a), .dut_b(d1_b),
    .dut_out(d1_out), .busy(d1_busy), .done(d1_done), .pass(d1_pass),
    .err_vec(d1_err_vec), .err_bits(d1_err_bits), .vec_idx(d1_vec)
  );

  assign m_a        = (sel == 1) ? d1_a        : d2_a;
  assign m_b        = (sel == 1) ? d1_b        : d2_b;
  assign m_busy     = (sel == 1) ? d1_busy     : d2_busy;
  assign m_done     = (sel == 1) ? d1_done     : d2_done;
  assign m_pass     = (sel == 1) ? d1_pass     : d2_pass;
  assign m_err_vec  = (sel == 1) ? d1_err_vec  : d2_err_vec;
  assign m_err_bits = (sel == 1) ? d1_err_bits : d2_err_bits;
  assign m_vec      = (sel == 1) ? d1_vec      : d2_vec;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 1) start1 = v;
    else          start2 = v;
  endtask

  // Start a run on the selected checker (called #1 after an edge); collects
  // the {a,b} sequence while busy, done count and done cycle number.
  task automatic run(input bit glitch, input bit b2b, output int lat, output int ndone,
                     output logic [31:0] seq, output int nbusy);
    lat = -1; ndone = 0; seq = '0; nbusy = 0;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    check("clear_on_start", {28'd0, m_pass, m_err_vec[2:0]}, 32'd0);
    if (m_busy) begin seq = {seq[29:0], m_a, m_b}; nbusy++; end
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      if (m_busy) begin seq = {seq[29:0], m_a, m_b}; nbusy++; end
      if (m_done) begin
        ndone++;
        if (lat < 0) lat = n + 1;
      end
      set_start(glitch && (n == 1 || n == 6));
      if (b2b && lat >= 0 && n == lat) break;
    end
  endtask

  function automatic logic [31:0] exp_seq(input int settle);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 4 * (settle + 1); k++) begin
      s = {s[29:0], 2'(k / (settle + 1))};
    end
    return s;
  endfunction

  int lat, ndone, nbusy, cnt;
  logic [31:0] seq;

  initial begin
    // Reset state
    #12;
    check("reset_state2", {18'd0, d2_a, d2_b, d2_vec, d2_busy, d2_done, d2_pass, d2_err_vec, d2_err_bits}, 32'd0);
    check("reset_state1", {18'd0, d1_a, d1_b, d1_vec, d1_busy, d1_done, d1_pass, d1_err_vec, d1_err_bits}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean run, settle 2
    sel = 0; fault2 = 0;
    run(1'b0, 1'b0, lat, ndone, seq, nbusy);
    check("good_latency", 32'(lat), 32'd13);
    check("good_ndone", 32'(ndone), 32'd1);
    check("good_nbusy", 32'(nbusy), 32'd12);
    check("good_seq", seq, exp_seq(2));
    check("good_pass", {31'd0, m_pass}, 32'd1);
    check("good_err_vec", {28'd0, m_err_vec}, 32'd0);
    check("good_err_bits", {25'd0, m_err_bits}, 32'd0);
    check("good_hold_ab_idx", {28'd0, m_a, m_b, m_vec}, 32'hF);

    // xorab stuck at 0
    fault2 = 1;
    run(1'b0, 1'b0, lat, ndone, seq, nbusy);
    check("xor0_err_vec", {28'd0, m_err_vec}, 32'b0110);
    check("xor0_err_bits", {25'd0, m_err_bits}, 32'b0100000);
    check("xor0_pass", {31'd0, m_pass}, 32'd0);

    // andab/nandab swapped
    fault2 = 2;
    run(1'b0, 1'b0, lat, ndone, seq, nbusy);
    check("swap_err_vec", {28'd0, m_err_vec}, 32'b1111);
    check("swap_err_bits", {25'd0, m_err_bits}, 32'b0010100);
    check("swap_pass", {31'd0, m_pass}, 32'd0);

    // start re-pulsed mid-run is ignored
    fault2 = 0;
    run(1'b1, 1'b0, lat, ndone, seq, nbusy);
    check("glitch_latency", 32'(lat), 32'd13);
    check("glitch_ndone", 32'(ndone), 32'd1);
    check("glitch_seq", seq, exp_seq(2));
    check("glitch_pass", {31'd0, m_pass}, 32'd1);

    // Reset mid-run: drop in cycle 6, release in cycle 8
    fault2 = 1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_busy", {31'd0, d2_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outs", {18'd0, d2_a, d2_b, d2_vec, d2_busy, d2_done, d2_pass, d2_err_vec, d2_err_bits}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 16; n++) begin
      @(posedge clk); #1;
      if (d2_done || d2_busy) cnt++;
    end
    check("no_done_after_abort", 32'(cnt), 32'd0);
    fault2 = 0;
    run(1'b0, 1'b0, lat, ndone, seq, nbusy);
    check("post_reset_latency", 32'(lat), 32'd13);
    check("post_reset_pass", {31'd0, m_pass}, 32'd1);
    check("post_reset_err", {21'd0, m_err_vec, m_err_bits}, 32'd0);

    // Settle 1, back-to-back runs: faulty then clean
    sel = 1; fault1 = 1;
    run(1'b0, 1'b1, lat, ndone, seq, nbusy);
    check("s1_latency", 32'(lat), 32'd9);
    check("s1_seq", seq, exp_seq(1));
    check("s1_run1_err_vec", {28'd0, m_err_vec}, 32'b0110);
    check("s1_run1_pass", {31'd0, m_pass}, 32'd0);
    fault1 = 0;
    run(1'b0, 1'b0, lat, ndone, seq, nbusy);
    check("s1_run2_latency", 32'(lat), 32'd9);
    check("s1_run2_ndone", 32'(ndone), 32'd1);
    check("s1_run2_err", {21'd0, m_err_vec, m_err_bits}, 32'd0);
    check("s1_run2_pass", {31'd0, m_pass}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
